// File: rtl/pkt_sched_pkg.sv
// Shared constants, the per-channel configuration record and the channel-index
// width helper for the packet scheduling timer.
package pkt_sched_pkg;

  localparam int CLK_HZ            = 50_000_000;
  localparam int DEFAULT_PERIOD_1S = 50_000_000;

  // Widest period a configuration record can carry; CNT_W must not exceed it.
  localparam int CFG_PERIOD_W = 32;

  typedef struct packed {
    logic [CFG_PERIOD_W-1:0] period;
    logic                    en;
    logic                    oneshot;
  } ch_cfg_t;

  // Channel index width, never narrower than one bit.
  function automatic int ch_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/pkt_sched_ch.sv
// One timer channel: period counter, expiry tick, one-shot disable, pending
// request flag and saturating overrun counter.
module pkt_sched_ch
  import pkt_sched_pkg::*;
#(
  parameter int   CNT_W          = 32,
  parameter int   OVR_W          = 8,
  parameter int   DEFAULT_PERIOD = DEFAULT_PERIOD_1S,
  parameter logic DEFAULT_EN     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cfg_we,
  input  ch_cfg_t          i_cfg,
  input  logic             i_accept,
  output logic             o_tick,
  output logic             o_pending,
  output logic [OVR_W-1:0] o_ovr
);

  logic [CNT_W-1:0] r_cnt;
  ch_cfg_t          r_cfg;
  logic             r_pending;
  logic [OVR_W-1:0] r_ovr;

  logic [CNT_W-1:0] w_period;
  logic [CNT_W-1:0] w_last;
  logic             w_expire;

  // Periods 0 and 1 share terminal count 0, so both expire every cycle.
  assign w_period = r_cfg.period[CNT_W-1:0];
  assign w_last   = (w_period == '0) ? '0 : w_period - CNT_W'(1);
  // A config write in the same cycle wins over expiry.
  assign w_expire = r_cfg.en && (r_cnt == w_last) && !i_cfg_we;

  assign o_tick    = w_expire;
  assign o_pending = r_pending;
  assign o_ovr     = r_ovr;

  // Counter, config, pending and overrun state update.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_cnt          <= '0;
      r_cfg.period   <= CFG_PERIOD_W'(DEFAULT_PERIOD);
      r_cfg.en       <= DEFAULT_EN;
      r_cfg.oneshot  <= 1'b0;
      r_pending      <= 1'b0;
      r_ovr          <= '0;
    end else begin
      if (i_cfg_we) begin
        r_cfg <= i_cfg;
        r_cnt <= '0;
      end else begin
        if (!r_cfg.en || w_expire) r_cnt <= '0;
        else                       r_cnt <= r_cnt + CNT_W'(1);
        if (w_expire && r_cfg.oneshot) r_cfg.en <= 1'b0;
      end

      // Re-expiry in the accept cycle keeps the request alive.
      if (w_expire)      r_pending <= 1'b1;
      else if (i_accept) r_pending <= 1'b0;

      if (i_cfg_we)
        r_ovr <= '0;
      else if (w_expire && r_pending && !i_accept && (r_ovr != '1))
        r_ovr <= r_ovr + OVR_W'(1);
    end
  end

endmodule

// File: rtl/pkt_sched_timer.sv
// Multi-channel programmable packet trigger: NUM_CH timer channels feeding a
// round-robin valid/ready request port that holds its offer until accepted.
module pkt_sched_timer
  import pkt_sched_pkg::*;
#(
  parameter int                NUM_CH         = 4,
  parameter int                CNT_W          = 32,
  parameter int                OVR_W          = 8,
  parameter int                DEFAULT_PERIOD = DEFAULT_PERIOD_1S,
  parameter logic [NUM_CH-1:0] DEFAULT_EN     = '0,
  localparam int               CH_W           = ch_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cfg_we,
  input  logic [CH_W-1:0]         i_cfg_ch,
  input  logic [CNT_W-1:0]        i_cfg_period,
  input  logic                    i_cfg_en,
  input  logic                    i_cfg_oneshot,
  output logic [NUM_CH-1:0]       o_tick,
  output logic                    o_req_valid,
  output logic [CH_W-1:0]         o_req_chan,
  input  logic                    i_req_ready,
  output logic [NUM_CH*OVR_W-1:0] o_ovr_cnt
);

  ch_cfg_t           w_cfg;
  logic [NUM_CH-1:0] w_we;
  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_accept;
  logic [CH_W-1:0]   w_rr_pick;
  logic [CH_W-1:0]   w_req_chan;
  logic              w_req_valid;

  logic [CH_W-1:0]   r_rr_ptr;
  logic              r_lock;
  logic [CH_W-1:0]   r_lock_ch;

  assign w_cfg = '{period: CFG_PERIOD_W'(i_cfg_period), en: i_cfg_en, oneshot: i_cfg_oneshot};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range channel numbers match no decoder and are dropped.
    assign w_we[i]     = i_cfg_we && (i_cfg_ch == CH_W'(i));
    assign w_accept[i] = w_req_valid && i_req_ready && (w_req_chan == CH_W'(i));

    pkt_sched_ch #(
      .CNT_W          (CNT_W),
      .OVR_W          (OVR_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD),
      .DEFAULT_EN     (DEFAULT_EN[i])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_cfg_we  (w_we[i]),
      .i_cfg     (w_cfg),
      .i_accept  (w_accept[i]),
      .o_tick    (o_tick[i]),
      .o_pending (w_pending[i]),
      .o_ovr     (o_ovr_cnt[i*OVR_W +: OVR_W])
    );
  end

  // Round-robin search: first pending channel above rr_ptr, wrapping.
  always_comb begin
    int   idx;
    logic found;
    // NOTE: every variable gets a default before any conditional write, so no
    // path leaves it unassigned and no latch is inferred.
    idx       = 0;
    found     = 1'b0;
    w_rr_pick = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && w_pending[idx]) begin
        found     = 1'b1;
        w_rr_pick = CH_W'(idx);
      end
    end
  end

  assign w_req_valid = |w_pending;
  assign w_req_chan  = !w_req_valid ? '0 : (r_lock ? r_lock_ch : w_rr_pick);
  assign o_req_valid = w_req_valid;
  assign o_req_chan  = w_req_chan;

  // Lock a stalled offer so it cannot switch channel; advance rr_ptr on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= CH_W'(NUM_CH - 1);
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
    end else if (w_req_valid && i_req_ready) begin
      r_rr_ptr <= w_req_chan;
      r_lock   <= 1'b0;
    end else if (w_req_valid && !r_lock) begin
      r_lock    <= 1'b1;
      r_lock_ch <= w_rr_pick;
    end
  end

endmodule

// File: tb/tb_pkt_sched_timer.sv
// Directed bench for pkt_sched_timer: table-driven cycle vectors for the reset
// cadence and round-robin order, hand sequences for one-shot, overrun
// saturation, write-in-expiry-cycle and mid-operation reset.
module tb_pkt_sched_timer;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 32;
  localparam int OVR_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    cfg_we;
  logic [CH_W-1:0]         cfg_ch;
  logic [CNT_W-1:0]        cfg_period;
  logic                    cfg_en;
  logic                    cfg_oneshot;
  logic [NUM_CH-1:0]       tick;
  logic                    req_valid;
  logic [CH_W-1:0]         req_chan;
  logic                    req_ready;
  logic [NUM_CH*OVR_W-1:0] ovr_cnt;

  int checks   = 0;
  int failures = 0;

  pkt_sched_timer #(
    .NUM_CH         (NUM_CH),
    .CNT_W          (CNT_W),
    .OVR_W          (OVR_W),
    .DEFAULT_PERIOD (10),
    .DEFAULT_EN     (4'b0001)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_cfg_we      (cfg_we),
    .i_cfg_ch      (cfg_ch),
    .i_cfg_period  (cfg_period),
    .i_cfg_en      (cfg_en),
    .i_cfg_oneshot (cfg_oneshot),
    .o_tick        (tick),
    .o_req_valid   (req_valid),
    .o_req_chan    (req_chan),
    .i_req_ready   (req_ready),
    .o_ovr_cnt     (ovr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        we;
    logic [1:0]  ch;
    logic [31:0] per;
    logic        en;
    logic        os;
    logic [3:0]  tk;
    logic        vld;
    logic [1:0]  chn;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic we, input logic [1:0] ch,
                       input logic [31:0] per, input logic en, input logic os);
    req_ready   = rdy;
    cfg_we      = we;
    cfg_ch      = ch;
    cfg_period  = per;
    cfg_en      = en;
    cfg_oneshot = os;
  endtask

  task automatic add_vec(input logic rdy, input logic we, input logic [1:0] ch,
                         input logic [31:0] per, input logic [3:0] tk,
                         input logic vld, input logic [1:0] chn);
    vec_t v;
    v.rdy = rdy; v.we = we; v.ch = ch; v.per = per; v.en = we; v.os = 1'b0;
    v.tk = tk; v.vld = vld; v.chn = chn;
    vecs.push_back(v);
  endtask

  // Apply one vector per cycle; ovr_cnt must stay zero throughout a table.
  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      drive(vecs[i].rdy, vecs[i].we, vecs[i].ch, vecs[i].per, vecs[i].en, vecs[i].os);
      #1;
      check($sformatf("%s c%0d tick", tag, i), tick, vecs[i].tk);
      check($sformatf("%s c%0d valid", tag, i), req_valid, vecs[i].vld);
      check($sformatf("%s c%0d chan", tag, i), req_chan, vecs[i].chn);
      check($sformatf("%s c%0d ovr", tag, i), ovr_cnt, 0);
      step();
    end
    vecs.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_tick, first_k, other, tick_err, hold_err;

    // Reset values.
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    #1;
    check("reset tick", tick, 0);
    check("reset valid", req_valid, 0);
    check("reset chan", req_chan, 0);
    check("reset ovr", ovr_cnt, 0);
    rst = 1'b0;

    // Default-enabled ch0, period 10: ticks at 9,19,29, offered and taken next cycle.
    for (int c = 0; c <= 30; c++)
      add_vec(1, 0, 0, 0, (c % 10 == 9) ? 4'b0001 : 4'b0000, (c > 0) && (c % 10 == 0), 0);
    run_vecs("dflt");

    // One-shot ch2, period 5, with ch0 disabled first.
    drive(1, 1, 0, 10, 0, 0); step();
    drive(1, 1, 2, 5, 1, 1);  step();
    drive(1, 0, 0, 0, 0, 0);
    n_tick = 0; first_k = -1; other = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (tick[2]) begin
        n_tick++;
        if (first_k < 0) first_k = k;
      end
      if ((tick & 4'b1011) != 0) other++;
      if (k == 5) begin
        check("oneshot valid", req_valid, 1);
        check("oneshot chan", req_chan, 2);
      end
      step();
    end
    check("oneshot tick count", n_tick, 1);
    check("oneshot tick offset", first_k, 4);
    check("oneshot other ticks", other, 0);

    // ch1 period 3 with the transmitter stalled: lock, overrun, saturation.
    drive(0, 1, 1, 3, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    tick_err = 0; hold_err = 0;
    for (int j = 0; j < 800; j++) begin
      #1;
      if (tick !== ((j % 3 == 2) ? 4'b0010 : 4'b0000)) tick_err++;
      if (j >= 3 && (req_valid !== 1'b1 || req_chan !== 2'd1)) hold_err++;
      if (j == 3) begin
        check("stall valid", req_valid, 1);
        check("stall chan", req_chan, 1);
      end
      if (j == 5)   check("ovr j5", ovr_cnt, 32'h0000_0000);
      if (j == 6)   check("ovr j6", ovr_cnt, 32'h0000_0100);
      if (j == 9)   check("ovr j9", ovr_cnt, 32'h0000_0200);
      if (j == 767) check("ovr j767", ovr_cnt, 32'h0000_FE00);
      if (j == 768) check("ovr j768 sat", ovr_cnt, 32'h0000_FF00);
      if (j == 799) check("ovr j799 sat", ovr_cnt, 32'h0000_FF00);
      step();
    end
    check("stall tick pattern errors", tick_err, 0);
    check("stall hold errors", hold_err, 0);
    // Write lands on an expiry cycle: no tick, ovr zeroed, pending kept.
    drive(0, 1, 1, 3, 0, 0);
    #1;
    check("ch1 write suppresses tick", tick, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("ch1 write ovr cleared", ovr_cnt, 0);
    check("ch1 write pending kept", req_valid, 1);
    check("ch1 write chan", req_chan, 1);
    req_ready = 1'b1;
    step();
    #1;
    check("ch1 accepted", req_valid, 0);

    // ch0 period 4, rewritten to period 6 in its expiry cycle.
    drive(1, 1, 0, 4, 1, 0); step();
    drive(1, 0, 0, 0, 0, 0);
    other = 0;
    for (int j = 0; j < 3; j++) begin
      #1;
      if (tick != 0) other++;
      step();
    end
    check("ch0 pre-expiry ticks", other, 0);
    drive(1, 1, 0, 6, 1, 0);
    #1;
    check("ch0 write in expiry cycle tick", tick, 0);
    step();
    drive(1, 0, 0, 0, 0, 0);
    other = 0;
    for (int j = 0; j < 6; j++) begin
      #1;
      if (j < 5 && tick != 0) other++;
      if (j == 5) check("ch0 new period tick", tick, 4'b0001);
      step();
    end
    check("ch0 early ticks after rewrite", other, 0);
    drive(1, 1, 0, 6, 0, 0);
    #1;
    check("ch0 offered", req_valid, 1);
    check("ch0 offered chan", req_chan, 0);
    step();

    // ch3 period 2 locked while stalled, then reset mid-operation.
    drive(0, 1, 3, 2, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    #1; check("ch3 j0 tick", tick, 0);       step();
    #1; check("ch3 j1 tick", tick, 4'b1000); step();
    #1; check("ch3 j2 valid", req_valid, 1);
        check("ch3 j2 chan", req_chan, 3);    step();
    #1; check("ch3 j3 tick", tick, 4'b1000); step();
    #1; check("ch3 j4 chan", req_chan, 3);
        check("ch3 j4 ovr", ovr_cnt, 32'h0100_0000);
    rst = 1'b1;
    step();
    #1;
    check("midreset valid", req_valid, 0);
    check("midreset chan", req_chan, 0);
    check("midreset ovr", ovr_cnt, 0);
    check("midreset tick", tick, 0);
    step();
    rst = 1'b0;

    // Aligned expiry of all four channels (staggered writes, periods 7/6/5/4).
    add_vec(1, 1, 0, 7, 4'b0000, 0, 0);
    add_vec(1, 1, 1, 6, 4'b0000, 0, 0);
    add_vec(1, 1, 2, 5, 4'b0000, 0, 0);
    add_vec(1, 1, 3, 4, 4'b0000, 0, 0);
    add_vec(1, 0, 0, 0, 4'b0000, 0, 0);
    add_vec(1, 0, 0, 0, 4'b0000, 0, 0);
    add_vec(1, 0, 0, 0, 4'b0000, 0, 0);
    add_vec(1, 0, 0, 0, 4'b1111, 0, 0);   // c7
    add_vec(1, 0, 0, 0, 4'b0000, 1, 0);   // c8
    add_vec(1, 0, 0, 0, 4'b0000, 1, 1);
    add_vec(1, 0, 0, 0, 4'b0000, 1, 2);
    add_vec(1, 0, 0, 0, 4'b1000, 1, 3);   // c11 re-expiry while accepted
    add_vec(1, 0, 0, 0, 4'b0100, 1, 3);
    add_vec(1, 0, 0, 0, 4'b0010, 1, 2);
    add_vec(1, 0, 0, 0, 4'b0001, 1, 1);
    add_vec(1, 0, 0, 0, 4'b1000, 1, 0);   // c15
    add_vec(1, 0, 0, 0, 4'b0000, 1, 3);
    add_vec(1, 0, 0, 0, 4'b0100, 0, 0);
    add_vec(1, 0, 0, 0, 4'b0000, 1, 2);
    add_vec(1, 0, 0, 0, 4'b1010, 0, 0);   // c19
    add_vec(1, 0, 0, 0, 4'b0000, 1, 3);   // rr_ptr=2: ch3 ahead of ch1
    add_vec(1, 0, 0, 0, 4'b0001, 1, 1);
    add_vec(1, 0, 0, 0, 4'b0100, 1, 0);   // c22
    run_vecs("rr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
